fpu_unpack_stage: RTL and testbench
===================================

// Module: fpu_unpack_stage
// PURPOSE
// - Pipelined FPU operand front end. Takes a raw 32-bit rs1 (IEEE-754 binary32, or an integer for int->fp ops).
// - Produces unbiased signed exponent, 24-bit significand with explicit leading one, and a 6-bit one-hot class.
// - Sits directly upstream of the FCVT conversion datapath and feeds rs1/rs1Exp/rs1Sig/rs1Class/instr/rm to it.
// - Registered valid/ready stage with 2-entry skid buffer; full throughput, 1-cycle latency.
// PARAMETERS
// - TAG_W   4   width of the opaque tag (e.g. rd index) carried alongside the operand
// PORTS
// - clk_i        in   1    clock, rising edge
// - rst_i        in   1    reset, asynchronous, active-high
// - flush_i      in   1    synchronous flush: drop all buffered operands
// - in_valid_i   in   1    upstream operand valid
// - in_ready_o   out  1    stage can accept (registered, depends only on skid occupancy)
// - in_rs1_i     in   32   raw operand bits
// - in_instr_i   in   2    {fp->int, unsigned}, passed through
// - in_rm_i      in   3    rounding mode, passed through
// - in_tag_i     in   TAG_W  passed through
// - out_valid_o  out  1    unpacked operand valid
// - out_ready_i  in   1    downstream accepts
// - out_rs1_o    out  32   raw operand, unchanged
// - out_exp_o    out  10   signed unbiased exponent
// - out_sig_o    out  24   significand, bit 23 = leading one (0 for zero)
// - out_class_o  out  6    one-hot class
// - out_instr_o, out_rm_o, out_tag_o  out  2/3/TAG_W  pass-through
// BEHAVIOUR
// - Reset: out_valid_o=0, in_ready_o=1, all data outputs 0, skid empty.
// - Transfer on valid&ready at each side; in_valid_i must hold with stable data until accepted.
// - Latency 1 cycle when out_ready_i=1: accepted in cycle N, presented in cycle N+1. One operand per cycle sustained.
// - Skid: main reg + 1 skid entry. in_ready_o=0 only when both are full. Strict FIFO order; no drop, no duplicate.
// - Simultaneous accept-in and accept-out with both entries full is impossible (in_ready_o=0). With one full: entry shifts, new data fills.
// - flush_i: both entries invalid next cycle, in_ready_o=1. Input offered in the same cycle is dropped. flush_i has priority over reset-free ops.
// - Async reset mid-transfer: immediate return to reset state; the in-flight operand is lost.
// - Unpack (E=bits[30:23], F=bits[22:0]), computed combinationally before the main register:
//   E=1..254: exp=E-127, sig={1,F}, class NORMAL.
//   E=0,F=0: exp=0, sig=0, class ZERO.
//   E=0,F!=0: p=index of leading one of F; sig=F<<(23-p); exp=p-149; class SUBNORMAL. Uses CLZ.
//   E=255,F=0: exp=128, sig=24'h800000, class INF.
//   E=255,F!=0: exp=128, sig={1,F}; class QNAN if F[22] else SNAN.
// - Sign is never folded into exp/sig; consumers read out_rs1_o[31].
// - Unpack fields are computed for every operand, including int->fp ops, where consumers ignore them.
// CONFIGURATION
// - FPU_UNPACK_FTZ_EN defined: subnormal inputs unpack as ZERO (exp=0, sig=0). out_rs1_o is unchanged, so the sign is kept.
// - FPU_UNPACK_FTZ_EN undefined: full subnormal normalisation as above.
// STRUCTURE
// - Class bit indices (CLASS_BIT_ZERO/SUBNORMAL/NORMAL/INF/SNAN/QNAN = 0..5) and INF_NAN_MASK live in the shared FClassFlags.vh.
// - Sub-module: existing CLZ #(.W_IN(32)) instance on {F,9'b0} for the subnormal leading-one search.
// - Pipeline register and skid entry share one packed payload struct: {rs1, exp, sig, class, instr, rm, tag}.
// TESTING
// - 0x3FC00000 (1.5), out_ready_i=1 -> next cycle: exp=0, sig=0xC00000, class NORMAL.
// - 0x00000001 -> exp=10'h36B (-149), sig=0x800000, SUBNORMAL. With FTZ_EN: exp=0, sig=0, ZERO.
// - 0xFF800000 -> exp=128, INF, out_rs1_o[31]=1. 0x7FC00000 -> QNAN. 0x7F800001 -> SNAN. 0x80000000 -> ZERO.
// - Back-pressure: 4 back-to-back inputs, out_ready_i=0 for 3 cycles.
//   -> in_ready_o drops after 2 accepted; all 4 emerge in order, no loss or duplication.
// - Back-to-back 1000 random operands, out_ready_i=1 -> one output per cycle. Fields match a reference unpack model.
// - flush_i with 2 buffered -> out_valid_o=0 next cycle, in_ready_o=1.
//   rst_i asserted mid-stream -> outputs 0 immediately, asynchronously.

Source files
------------

// File: rtl/fpu_unpack_stage_pkg.sv
// rtl/fpu_unpack_stage_pkg.sv - class bit indices, field widths and unpacked operand type
package fpu_unpack_stage_pkg;

    localparam int CLASS_W             = 6;
    localparam int CLASS_BIT_ZERO      = 0;
    localparam int CLASS_BIT_SUBNORMAL = 1;
    localparam int CLASS_BIT_NORMAL    = 2;
    localparam int CLASS_BIT_INF       = 3;
    localparam int CLASS_BIT_SNAN      = 4;
    localparam int CLASS_BIT_QNAN      = 5;

    // Classes whose exponent field is pinned to the reserved value 128
    localparam logic [CLASS_W-1:0] INF_NAN_MASK = 6'b111000;

    localparam int EXP_W    = 10;
    localparam int SIG_W    = 24;
    localparam int EXP_BIAS = 127;

    typedef struct packed {
        logic [31:0]        rs1;
        logic [EXP_W-1:0]   exp;
        logic [SIG_W-1:0]   sig;
        logic [CLASS_W-1:0] cls;
    } unpacked_t;

endpackage

// File: rtl/fpu_unpack_stage_clz.sv
// rtl/fpu_unpack_stage_clz.sv - count leading zeros, returns W_IN for an all-zero input
module fpu_unpack_stage_clz #(
    parameter int  W_IN  = 32,
    localparam int CNT_W = $clog2(W_IN) + 1
) (
    input  logic [W_IN-1:0]  in_i,
    output logic [CNT_W-1:0] cnt_o
);

    // Scan upward so the highest set bit is the last one to write the count
    always_comb begin
        cnt_o = CNT_W'(W_IN);
        for (int i = 0; i < W_IN; i++) begin
            if (in_i[i]) begin
                cnt_o = CNT_W'(W_IN - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fpu_unpack_stage.sv
// rtl/fpu_unpack_stage.sv - binary32 operand unpack with registered valid/ready skid stage (FPU_UNPACK_FTZ_EN: flush subnormals to zero)
module fpu_unpack_stage
    import fpu_unpack_stage_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               flush_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [31:0]        in_rs1_i,
    input  logic [1:0]         in_instr_i,
    input  logic [2:0]         in_rm_i,
    input  logic [TAG_W-1:0]   in_tag_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [31:0]        out_rs1_o,
    output logic [EXP_W-1:0]   out_exp_o,
    output logic [SIG_W-1:0]   out_sig_o,
    output logic [CLASS_W-1:0] out_class_o,
    output logic [1:0]         out_instr_o,
    output logic [2:0]         out_rm_o,
    output logic [TAG_W-1:0]   out_tag_o
);

    typedef struct packed {
        unpacked_t        op;
        logic [1:0]       instr;
        logic [2:0]       rm;
        logic [TAG_W-1:0] tag;
    } payload_t;

    logic [7:0]  e_w;
    logic [22:0] f_w;
    unpacked_t   unp_w;
    payload_t    in_pl_w;

    payload_t main_q, main_d, skid_q, skid_d;
    logic     main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;

    assign e_w = in_rs1_i[30:23];
    assign f_w = in_rs1_i[22:0];

`ifndef FPU_UNPACK_FTZ_EN
    logic [5:0] lz_w;

    fpu_unpack_stage_clz #(.W_IN(32)) u_clz (
        .in_i  ({f_w, 9'b0}),
        .cnt_o (lz_w)
    );
`endif

    // Field decode; sign stays only in rs1 so consumers see magnitude fields
    always_comb begin
        unp_w     = '0;
        unp_w.rs1 = in_rs1_i;
        if (e_w == 8'hFF) begin
            unp_w.sig = {1'b1, f_w};
            if (f_w == '0) begin
                unp_w.cls[CLASS_BIT_INF] = 1'b1;
            end else if (f_w[22]) begin
                unp_w.cls[CLASS_BIT_QNAN] = 1'b1;
            end else begin
                unp_w.cls[CLASS_BIT_SNAN] = 1'b1;
            end
        end else if (e_w != 8'h00) begin
            unp_w.exp = {2'b00, e_w} - 10'(EXP_BIAS);
            unp_w.sig = {1'b1, f_w};
            unp_w.cls[CLASS_BIT_NORMAL] = 1'b1;
        end else if (f_w == '0) begin
            unp_w.cls[CLASS_BIT_ZERO] = 1'b1;
        end else begin
`ifdef FPU_UNPACK_FTZ_EN
            unp_w.cls[CLASS_BIT_ZERO] = 1'b1;
`else
            // Leading one of F sits at bit 22-lz; shift it up to bit 23
            unp_w.exp = -10'(EXP_BIAS) - {4'b0000, lz_w};
            unp_w.sig = {1'b0, f_w} << (lz_w + 6'd1);
            unp_w.cls[CLASS_BIT_SUBNORMAL] = 1'b1;
`endif
        end
        if (|(unp_w.cls & INF_NAN_MASK)) begin
            unp_w.exp = 10'd128;
        end
    end

    assign in_pl_w = '{op: unp_w, instr: in_instr_i, rm: in_rm_i, tag: in_tag_i};

    // Skid control: main register advances from skid first, then from the input
    always_comb begin
        main_d       = main_q;
        main_valid_d = main_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (flush_i) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q || out_ready_i) begin
            if (skid_valid_q) begin
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else begin
                main_valid_d = in_valid_i;
                if (in_valid_i) begin
                    main_d = in_pl_w;
                end
            end
        end else if (in_valid_i && !skid_valid_q) begin
            skid_d       = in_pl_w;
            skid_valid_d = 1'b1;
        end
    end

    // State registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign in_ready_o  = ~skid_valid_q;
    assign out_valid_o = main_valid_q;
    assign out_rs1_o   = main_q.op.rs1;
    assign out_exp_o   = main_q.op.exp;
    assign out_sig_o   = main_q.op.sig;
    assign out_class_o = main_q.op.cls;
    assign out_instr_o = main_q.instr;
    assign out_rm_o    = main_q.rm;
    assign out_tag_o   = main_q.tag;

endmodule

// File: tb/tb_fpu_unpack_stage.sv
// tb/tb_fpu_unpack_stage.sv - randomized and directed self-check of fpu_unpack_stage against an arithmetic model
module tb_fpu_unpack_stage;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        flush_i = 1'b0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [31:0] in_rs1_i = '0;
    logic [1:0]  in_instr_i = '0;
    logic [2:0]  in_rm_i = '0;
    logic [3:0]  in_tag_i = '0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b1;
    logic [31:0] out_rs1_o;
    logic [9:0]  out_exp_o;
    logic [23:0] out_sig_o;
    logic [5:0]  out_class_o;
    logic [1:0]  out_instr_o;
    logic [2:0]  out_rm_o;
    logic [3:0]  out_tag_o;

    int nchk = 0;
    int nerr = 0;
    int cyc  = 0;

    typedef struct packed {
        logic [31:0] rs1;
        logic [9:0]  exp;
        logic [23:0] sig;
        logic [5:0]  cls;
        logic [1:0]  instr;
        logic [2:0]  rm;
        logic [3:0]  tag;
    } item_t;

    item_t q[$];
    item_t got, want;
    logic  model_rdy;

    fpu_unpack_stage #(.TAG_W(4)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_rs1_i    (in_rs1_i),
        .in_instr_i  (in_instr_i),
        .in_rm_i     (in_rm_i),
        .in_tag_i    (in_tag_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_rs1_o   (out_rs1_o),
        .out_exp_o   (out_exp_o),
        .out_sig_o   (out_sig_o),
        .out_class_o (out_class_o),
        .out_instr_o (out_instr_o),
        .out_rm_o    (out_rm_o),
        .out_tag_o   (out_tag_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    // Class numbering: 0 zero, 1 subnormal, 2 normal, 3 inf, 4 snan, 5 qnan
    function automatic item_t ref_unpack(input logic [31:0] x, input logic [1:0] instr,
                                         input logic [2:0] rm, input logic [3:0] tag);
        item_t r;
        int e, f, ex, sg, c, p;
        e = int'(x[30:23]);
        f = int'(x[22:0]);
        ex = 0; sg = 0; c = 0;
        if (e == 255) begin
            ex = 128;
            sg = f + (1 << 23);
            if (f == 0) c = 3;
            else if (((f >> 22) & 1) == 1) c = 5;
            else c = 4;
        end else if (e > 0) begin
            ex = e - 127;
            sg = f + (1 << 23);
            c  = 2;
        end else if (f != 0) begin
`ifndef FPU_UNPACK_FTZ_EN
            p = 22;
            while (((f >> p) & 1) == 0) p--;
            sg = f * (1 << (23 - p));
            ex = p - 149;
            c  = 1;
`endif
        end
        r.rs1 = x;
        r.exp = 10'(ex);
        r.sig = 24'(sg);
        r.cls = 6'(1 << c);
        r.instr = instr;
        r.rm = rm;
        r.tag = tag;
        return r;
    endfunction

    // Compare DUT against the queue model every cycle, then advance the model
    always @(negedge clk_i) begin
        if (rst_i) q.delete();
        model_rdy = (q.size() < 2);
        nchk++;
        if (out_valid_o !== (q.size() > 0)) begin
            nerr++;
            $display("FAIL out_valid: got %b want %b (t=%0t)", out_valid_o, q.size() > 0, $time);
        end
        nchk++;
        if (in_ready_o !== model_rdy) begin
            nerr++;
            $display("FAIL in_ready: got %b want %b (t=%0t)", in_ready_o, model_rdy, $time);
        end
        if (out_valid_o && q.size() > 0) begin
            got = '{out_rs1_o, out_exp_o, out_sig_o, out_class_o, out_instr_o, out_rm_o, out_tag_o};
            nchk++;
            if (got !== q[0]) begin
                nerr++;
                $display("FAIL payload: got rs1=%h exp=%h sig=%h cls=%b ins=%h rm=%h tag=%h want rs1=%h exp=%h sig=%h cls=%b ins=%h rm=%h tag=%h",
                         got.rs1, got.exp, got.sig, got.cls, got.instr, got.rm, got.tag,
                         q[0].rs1, q[0].exp, q[0].sig, q[0].cls, q[0].instr, q[0].rm, q[0].tag);
            end
        end
        if (!rst_i) begin
            if (flush_i) begin
                q.delete();
            end else begin
                if (out_valid_o && out_ready_i && q.size() > 0) void'(q.pop_front());
                if (in_valid_i && model_rdy)
                    q.push_back(ref_unpack(in_rs1_i, in_instr_i, in_rm_i, in_tag_i));
            end
        end
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Offer one operand and hold it until accepted; returns 1 ns after the accepting edge
    task automatic push(input logic [31:0] rs1);
        int n;
        n = 0;
        in_valid_i = 1'b1;
        in_rs1_i   = rs1;
        in_instr_i = 2'($urandom);
        in_rm_i    = 3'($urandom);
        in_tag_i   = 4'($urandom);
        do begin
            @(negedge clk_i);
            n++;
        end while (!in_ready_o && n < 50);
        if (n >= 50) begin
            nchk++;
            nerr++;
            $display("FAIL push_timeout: got ready=0 for %0d cycles want ready=1", n);
        end
        @(posedge clk_i);
        #1;
        in_valid_i = 1'b0;
    endtask

    function automatic logic [31:0] gen_operand();
        logic [22:0] f;
        f = 23'($urandom);
        case ($urandom_range(0, 5))
            0: return {1'($urandom), 8'h00, f >> $urandom_range(0, 22)};
            1: return {1'($urandom), 31'h0};
            2: return {1'($urandom), 8'hFF, 23'h0};
            3: return {1'($urandom), 8'hFF, f};
            default: return $urandom;
        endcase
    endfunction

    task automatic directed(input string nm, input logic [31:0] rs1, input logic [9:0] ex,
                            input logic [23:0] sg, input logic [5:0] cl);
        out_ready_i = 1'b1;
        push(rs1);
        check({nm, "_valid"}, 64'(out_valid_o), 64'd1);
        check({nm, "_rs1"}, 64'(out_rs1_o), 64'(rs1));
        check({nm, "_exp"}, 64'(out_exp_o), 64'(ex));
        check({nm, "_sig"}, 64'(out_sig_o), 64'(sg));
        check({nm, "_class"}, 64'(out_class_o), 64'(cl));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        logic stop;
        #12;
        check("reset_valid", 64'(out_valid_o), 64'd0);
        check("reset_ready", 64'(in_ready_o), 64'd1);
        check("reset_data", 64'({out_rs1_o, out_exp_o, out_sig_o} != 0), 64'd0);
        @(posedge clk_i);
        #2;
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;

        check("model_norm", 64'(ref_unpack(32'h3FC00000, 0, 0, 0).sig), 64'h00C00000);
`ifndef FPU_UNPACK_FTZ_EN
        check("model_sub", 64'(ref_unpack(32'h00000001, 0, 0, 0).exp), 64'h36B);
`endif

        directed("norm_1p5", 32'h3FC00000, 10'h000, 24'hC00000, 6'b000100);
`ifdef FPU_UNPACK_FTZ_EN
        directed("sub_min", 32'h00000001, 10'h000, 24'h000000, 6'b000001);
`else
        directed("sub_min", 32'h00000001, 10'h36B, 24'h800000, 6'b000010);
`endif
        directed("neg_inf", 32'hFF800000, 10'd128, 24'h800000, 6'b001000);
        check("neg_inf_sign", 64'(out_rs1_o[31]), 64'd1);
        directed("qnan", 32'h7FC00000, 10'd128, 24'hC00000, 6'b100000);
        directed("snan", 32'h7F800001, 10'd128, 24'h800001, 6'b010000);
        directed("neg_zero", 32'h80000000, 10'h000, 24'h000000, 6'b000001);
        directed("max_norm", 32'h7F7FFFFF, 10'd127, 24'hFFFFFF, 6'b000100);

        // Back-pressure: four operands against a stalled consumer
        @(posedge clk_i);
        #1;
        out_ready_i = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++) push(gen_operand());
            end
            begin
                repeat (2) @(posedge clk_i);
                #1;
                check("bp_ready_drop", 64'(in_ready_o), 64'd0);
                @(posedge clk_i);
                #1;
                out_ready_i = 1'b1;
            end
        join
        repeat (4) @(posedge clk_i);
        #1;
        check("bp_drained", 64'(q.size()), 64'd0);

        // Full-rate stream
        c0 = cyc;
        for (int i = 0; i < 1000; i++) push(gen_operand());
        check("throughput_cycles", 64'(cyc - c0), 64'd1000);

        // Random consumer stalls
        stop = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) push(gen_operand());
                stop = 1'b1;
            end
            begin
                while (!stop) begin
                    @(posedge clk_i);
                    #1;
                    out_ready_i = 1'($urandom);
                end
            end
        join
        out_ready_i = 1'b1;
        repeat (4) @(posedge clk_i);
        #1;
        check("rand_drained", 64'(q.size()), 64'd0);

        // Flush with both entries occupied, plus a dropped same-cycle offer
        out_ready_i = 1'b0;
        push(32'h40000000);
        push(32'h40400000);
        check("flush_pre_ready", 64'(in_ready_o), 64'd0);
        in_valid_i = 1'b1;
        in_rs1_i   = 32'h40800000;
        flush_i    = 1'b1;
        @(posedge clk_i);
        #1;
        flush_i    = 1'b0;
        in_valid_i = 1'b0;
        check("flush_valid", 64'(out_valid_o), 64'd0);
        check("flush_ready", 64'(in_ready_o), 64'd1);
        out_ready_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        check("flush_no_ghost", 64'(out_valid_o), 64'd0);

        // Asynchronous reset with an operand held
        out_ready_i = 1'b0;
        push(32'hC0490FDB);
        #2;
        rst_i = 1'b1;
        #1;
        check("arst_valid", 64'(out_valid_o), 64'd0);
        check("arst_ready", 64'(in_ready_o), 64'd1);
        check("arst_data", 64'({out_rs1_o, out_exp_o, out_sig_o, out_class_o} != 0), 64'd0);
        @(posedge clk_i);
        #2;
        rst_i = 1'b0;
        out_ready_i = 1'b1;
        directed("post_rst", 32'h3F800000, 10'h000, 24'h800000, 6'b000100);
        repeat (2) @(posedge clk_i);
        #1;

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
